// File: rtl/r2r_wave_mux.sv
// r2r_wave_mux: glitch-free source select, amplitude scale and R2R output register.
// Optional output slew limiting in RUN is enabled with `define R2R_SLEW_LIMIT_EN.
module r2r_wave_mux #(
  parameter int WIDTH       = 8,
  parameter int GAIN_W      = 8,
  parameter int DRAIN_STEP  = 4,
  parameter int ARM_TIMEOUT = 1023,
  parameter int SLEW_STEP   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               step_tick,
  input  logic [4*WIDTH-1:0] wave_in,
  input  logic [1:0]         sel,
  input  logic [GAIN_W-1:0]  gain,
  output logic [WIDTH-1:0]   R2R_output,
  output logic [1:0]         active_sel,
  output logic               busy
);

  localparam int CW = $clog2(ARM_TIMEOUT + 1);
  localparam int PW = WIDTH + GAIN_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARM   = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [CW-1:0]    CNT_MAX = CW'(ARM_TIMEOUT);
  localparam logic [WIDTH-1:0] DSTEP   = WIDTH'(DRAIN_STEP);

  logic [1:0]       state, state_n;
  logic [1:0]       pend_sel, pend_n;
  logic [1:0]       act_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] out_n;
  logic             busy_n;

  logic [WIDTH-1:0] act_code;
  logic [WIDTH-1:0] pend_code;
  logic [GAIN_W:0]  gain_p1;
  logic [PW-1:0]    prod;
  logic [WIDTH-1:0] tgt;
  logic [WIDTH-1:0] run_val;
  logic [WIDTH-1:0] drain_val;

  // Scale the active source; gain+1 keeps all-ones gain at exact unity.
  always_comb begin
    act_code  = wave_in[active_sel*WIDTH +: WIDTH];
    pend_code = wave_in[pend_sel*WIDTH +: WIDTH];
    gain_p1   = {1'b0, gain} + {{GAIN_W{1'b0}}, 1'b1};
    prod      = PW'(act_code) * PW'(gain_p1);
    tgt       = prod[GAIN_W +: WIDTH];
  end

`ifdef R2R_SLEW_LIMIT_EN
  localparam logic [WIDTH-1:0] SSTEP = WIDTH'(SLEW_STEP);

  // Move toward the target by at most SSTEP per clock.
  always_comb begin
    run_val = R2R_output;
    if (tgt > R2R_output) begin
      if (tgt - R2R_output > SSTEP)
        run_val = R2R_output + SSTEP;
      else
        run_val = tgt;
    end else if (tgt < R2R_output) begin
      if (R2R_output - tgt > SSTEP)
        run_val = R2R_output - SSTEP;
      else
        run_val = tgt;
    end
  end
`else
  // Unslewed: the target goes straight to the ladder.
  always_comb begin
    run_val = tgt;
  end
`endif

  // Saturating drain decrement toward zero.
  always_comb begin
    if (R2R_output > DSTEP)
      drain_val = R2R_output - DSTEP;
    else
      drain_val = '0;
  end

  // Next-state and datapath decisions; enable low overrides everything.
  always_comb begin
    state_n = state;
    pend_n  = pend_sel;
    act_n   = active_sel;
    cnt_n   = cnt;
    out_n   = R2R_output;
    if (!enable) begin
      state_n = S_IDLE;
      out_n   = '0;
      cnt_n   = '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          pend_n  = sel;
          out_n   = '0;
          state_n = S_ARM;
        end
        S_ARM: begin
          out_n = '0;
          if (sel != pend_sel) begin
            pend_n = sel;
            cnt_n  = '0;
          end else if (pend_code == '0 || cnt == CNT_MAX) begin
            act_n   = pend_sel;
            cnt_n   = '0;
            state_n = S_RUN;
          end else if (step_tick && cnt != CNT_MAX) begin
            cnt_n = cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (sel != active_sel) begin
            pend_n  = sel;
            state_n = S_DRAIN;
          end else begin
            out_n = run_val;
          end
        end
        S_DRAIN: begin
          if (sel != pend_sel)
            pend_n = sel;
          if (R2R_output == '0)
            state_n = S_ARM;
          else if (step_tick)
            out_n = drain_val;
        end
        default: begin
          state_n = S_IDLE;
          out_n   = '0;
          cnt_n   = '0;
        end
      endcase
    end
    busy_n = (state_n == S_ARM) || (state_n == S_DRAIN);
  end

  // State, selection, counter and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      pend_sel   <= 2'd0;
      active_sel <= 2'd0;
      cnt        <= '0;
      R2R_output <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      pend_sel   <= pend_n;
      active_sel <= act_n;
      cnt        <= cnt_n;
      R2R_output <= out_n;
      busy       <= busy_n;
    end
  end

endmodule
